// File: rtl/mux_stream_capture_if.sv
// Tile-side bus of the mux stream capture stage.
// master drives the tile inputs, slave is the capture stage.
interface mux_stream_capture_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/mux_stream_capture.sv
// Captures CAP_LEN serial samples of mux Y and holds them until acked.
// Optional INPUT_SYNC_EN adds a 2-flop synchronizer on ui_in[2:0].
module mux_stream_capture #(
  parameter int CAP_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_stream_capture_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    HOLD  = 2'b10,
    BAD   = 2'b11
  } state_e;

  localparam logic [2:0] LAST = 3'(CAP_LEN - 1);
  localparam logic [7:0] MASK = 8'((16'd1 << CAP_LEN) - 16'd1);

  logic data_s, start_s, ack_s;

`ifdef INPUT_SYNC_EN
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  assign sync1_d = bus.ui_in[2:0];
  assign sync2_d = sync1_q;
  assign data_s  = sync2_q[0];
  assign start_s = sync2_q[1];
  assign ack_s   = sync2_q[2];
`else
  assign data_s  = bus.ui_in[0];
  assign start_s = bus.ui_in[1];
  assign ack_s   = bus.ui_in[2];
`endif

  state_e     state_q, state_d;
  logic       start_q, start_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] tog_q, tog_d;
  logic       prev_q, prev_d;
  logic [7:0] uo_q, uo_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;

  logic       start_edge;
  logic [7:0] shift_nx;

  assign start_edge = start_s & ~start_q;
  assign shift_nx   = {shift_q[6:0], data_s};

  always_comb begin
    state_d   = state_q;
    start_d   = start_s;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tog_d     = tog_q;
    prev_d    = prev_q;
    uo_d      = uo_q;
    unique case (state_q)
      IDLE: begin
        shift_d   = '0;
        bit_cnt_d = '0;
        if (start_edge) begin
          state_d = SHIFT;
          tog_d   = '0;
        end
      end
      SHIFT: begin
        shift_d   = shift_nx;
        bit_cnt_d = bit_cnt_q + 3'd1;
        prev_d    = data_s;
        // first sample has no predecessor to toggle against
        if (bit_cnt_q != 3'd0 && data_s != prev_q)
          tog_d = tog_q + 4'd1;
        if (bit_cnt_q == LAST) begin
          state_d = HOLD;
          uo_d    = shift_nx & MASK;
        end
      end
      HOLD: begin
        if (ack_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == HOLD);
    busy_d  = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tog_q     <= '0;
      prev_q    <= 1'b0;
      uo_q      <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef INPUT_SYNC_EN
      sync1_q   <= '0;
      sync2_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tog_q     <= tog_d;
      prev_q    <= prev_d;
      uo_q      <= uo_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
`ifdef INPUT_SYNC_EN
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
`endif
    end
  end

  assign bus.uo_out  = uo_q;
  assign bus.uio_out = {tog_q, state_q, busy_q, valid_q};
  assign bus.uio_oe  = 8'hFF;

  logic unused;
  assign unused = &{1'b0, bus.ena, bus.uio_in, bus.ui_in[7:3]};

endmodule

// File: tb/tb_mux_stream_capture.sv
// Directed bench for mux_stream_capture (CAP_LEN 8 and 3).
// Expected captures go through a scoreboard queue.
module tb_mux_stream_capture;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_stream_capture_if if8 ();
  mux_stream_capture_if if3 ();

  mux_stream_capture #(.CAP_LEN(8)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  mux_stream_capture #(.CAP_LEN(3)) u3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3)
  );

  typedef struct {
    string      tag;
    logic [7:0] uo;
    logic [3:0] tog;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [3:0] tog_model(input logic [7:0] b, input int n);
    logic [3:0] t = 0;
    for (int i = n - 1; i > 0; i--)
      if (b[i] != b[i-1]) t++;
    return t;
  endfunction

  task automatic wait_valid8(input string tag);
    int n = 0;
    while (!if8.uio_out[0] && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid_wait"}, 32'(if8.uio_out[0]), 32'd1);
  endtask

  task automatic pop8(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({e.tag, "_uo"}, 32'(if8.uo_out), 32'(e.uo));
    check({e.tag, "_tog"}, 32'(if8.uio_out[7:4]), 32'(e.tog));
  endtask

  task automatic cap8(input string tag, input logic [7:0] bits,
                      input logic hold_start, input logic ack_in_shift,
                      input int mid_start_at);
    exp_t e;
    if8.ui_in = 8'b0000_0010;
    tick();
    check({tag, "_shift_entry"}, 32'(if8.uio_out[3:2]), 32'd1);
    e.tag = tag;
    e.uo  = bits;
    e.tog = tog_model(bits, 8);
    sb.push_back(e);
    for (int i = 0; i < 8; i++) begin
      if8.ui_in[0] = bits[7-i];
      if8.ui_in[1] = hold_start || (i == mid_start_at);
      if8.ui_in[2] = ack_in_shift;
      tick();
    end
    if8.ui_in[2] = 1'b0;
    check({tag, "_valid_busy_at8"}, 32'(if8.uio_out[1:0]), 32'h1);
    wait_valid8(tag);
    pop8(tag);
  endtask

  initial begin
    exp_t e3;
    rst_n       = 1'b0;
    if8.ena     = 1'b1;
    if8.uio_in  = 8'h00;
    if3.ena     = 1'b1;
    if3.uio_in  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      if8.ui_in = 8'($urandom);
      if3.ui_in = 8'($urandom);
      tick();
    end
    check("rst_uo8", 32'(if8.uo_out), 32'h00);
    check("rst_uio8", 32'(if8.uio_out), 32'h00);
    check("rst_oe8", 32'(if8.uio_oe), 32'hFF);
    check("rst_uo3", 32'(if3.uo_out), 32'h00);
    check("rst_uio3", 32'(if3.uio_out), 32'h00);
    check("rst_oe3", 32'(if3.uio_oe), 32'hFF);
    rst_n     = 1'b1;
    if8.ui_in = 8'h00;
    if3.ui_in = 8'h00;
    tick();
    check("idle_state8", 32'(if8.uio_out[3:2]), 32'd0);
    check("idle_state3", 32'(if3.uio_out[3:2]), 32'd0);

    cap8("basic", 8'hAC, 1'b0, 1'b0, -1);
    check("basic_tog5", 32'(if8.uio_out[7:4]), 32'd5);

    repeat (10) tick();
    check("hold_uo", 32'(if8.uo_out), 32'hAC);
    check("hold_valid", 32'(if8.uio_out[0]), 32'd1);
    if8.ui_in[2] = 1'b1;
    tick();
    if8.ui_in[2] = 1'b0;
    check("ack_valid", 32'(if8.uio_out[0]), 32'd0);
    check("ack_state", 32'(if8.uio_out[3:2]), 32'd0);
    tick();
    check("idle_uo", 32'(if8.uo_out), 32'hAC);

    cap8("ignored", 8'h65, 1'b0, 1'b1, 3);
    tick();
    check("ign_still_hold", 32'(if8.uio_out[1:0]), 32'h1);
    if8.ui_in[2] = 1'b1;
    tick();
    if8.ui_in[2] = 1'b0;
    check("ign_ack_state", 32'(if8.uio_out[3:2]), 32'd0);

    cap8("held", 8'hF0, 1'b1, 1'b0, -1);
    if8.ui_in[2] = 1'b1;
    tick();
    if8.ui_in[2] = 1'b0;
    repeat (4) tick();
    check("held_no_recap", 32'(if8.uio_out[3:2]), 32'd0);
    check("held_uo", 32'(if8.uo_out), 32'hF0);
    if8.ui_in[1] = 1'b0;
    tick();

    if8.ui_in = 8'b0000_0010;
    tick();
    if8.ui_in[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if8.ui_in[0] = 1'($urandom);
      tick();
    end
    check("mid_busy", 32'(if8.uio_out[1]), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_uo", 32'(if8.uo_out), 32'h00);
    check("mid_rst_uio", 32'(if8.uio_out), 32'h00);
    rst_n     = 1'b1;
    if8.ui_in = 8'h00;
    tick();
    check("mid_rst_idle", 32'(if8.uio_out[3:2]), 32'd0);

    if3.ui_in = 8'b0000_0010;
    tick();
    check("c3_shift", 32'(if3.uio_out[3:2]), 32'd1);
    e3.tag = "c3";
    e3.uo  = 8'h07;
    e3.tog = tog_model(8'h07, 3);
    sb.push_back(e3);
    for (int i = 0; i < 3; i++) begin
      if3.ui_in = 8'b0000_0001;
      tick();
    end
    check("c3_valid", 32'(if3.uio_out[1:0]), 32'h1);
    e3 = sb.pop_front();
    check("c3_uo", 32'(if3.uo_out), 32'(e3.uo));
    check("c3_tog", 32'(if3.uio_out[7:4]), 32'(e3.tog));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
